// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// StHdr exists only when UART_ARB_HEADER_EN is defined.
package uart_arb_pkg;

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [2:0] {StIdle, StHdr, StIssue, StWaitStart, StWaitEnd} arb_state_t;
`else
    typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitEnd} arb_state_t;
`endif

    localparam logic [3:0] HDR_PREFIX = 4'hA;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first set request at or after ptr_i,
// wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IdW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic           found_o,
    output logic [IdW-1:0] idx_o
);

    int j;

    // Walk from the farthest slot back to the pointer so the nearest one wins.
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        j       = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % int'(N);
            if (req_i[IdW'(j)]) begin
                idx_o = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 8N2 UART transmitter.
// Define UART_ARB_HEADER_EN to prefix each granted packet with {4'hA, grant_id}.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 8,
    localparam int unsigned IdW          = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 uart_transmit_o,
    output logic [7:0]           uart_tx_byte_o,
    input  logic                 uart_busy_i,
    output logic                 grant_active_o,
    output logic [IdW-1:0]       grant_id_o,
    output logic                 timeout_err_o
);

    localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);

`ifdef UART_ARB_HEADER_EN
    if (NUM_REQ > 16) begin : g_num_req_check
        $error("NUM_REQ must be <= 16 when the header byte is enabled");
    end
`endif

    arb_state_t      state_q, state_d;
    logic [IdW-1:0]  owner_q, owner_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic            last_q, last_d;
    logic            grant_q, grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            pick_found;
    logic [IdW-1:0]  pick_idx;
    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;
    logic [IdW-1:0]  owner_inc;
    logic            byte_done;

    rr_pick #(
        .N   (NUM_REQ),
        .IdW (IdW)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_valid    = req_valid_i[owner_q];
    assign owner_last     = req_last_i[owner_q];
    assign owner_data     = req_data_i[{owner_q, 3'b000} +: 8];
    assign owner_inc      = (owner_q == IdW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign grant_active_o = grant_q;
    assign grant_id_o     = owner_q;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        ptr_d           = ptr_q;
        last_d          = last_q;
        grant_d         = grant_q;
        cnt_d           = cnt_q;
        uart_transmit_o = 1'b0;
        uart_tx_byte_o  = '0;
        req_ready_o     = '0;
        timeout_err_o   = 1'b0;
        byte_done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    grant_d = 1'b1;
`ifdef UART_ARB_HEADER_EN
                    state_d = StHdr;
`else
                    state_d = StIssue;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            StHdr: begin
                uart_tx_byte_o = {HDR_PREFIX, 4'(owner_q)};
                if (!uart_busy_i) begin
                    uart_transmit_o = 1'b1;
                    last_d          = 1'b0;
                    cnt_d           = '0;
                    state_d         = StWaitStart;
                end
            end
`endif
            StIssue: begin
                uart_tx_byte_o = owner_data;
                if (owner_valid && !uart_busy_i) begin
                    uart_transmit_o      = 1'b1;
                    req_ready_o[owner_q] = 1'b1;
                    last_d               = owner_last;
                    cnt_d                = '0;
                    state_d              = StWaitStart;
                end
            end
            StWaitStart: begin
                cnt_d = cnt_q + 1'b1;
                if (uart_busy_i) begin
                    state_d = StWaitEnd;
                end else if (cnt_d == CntW'(START_TIMEOUT)) begin
                    // UART never started: count the byte as sent so the lock cannot hang.
                    timeout_err_o = 1'b1;
                    byte_done     = 1'b1;
                end
            end
            StWaitEnd: begin
                if (!uart_busy_i) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_done) begin
            if (last_q) begin
                state_d = StIdle;
                grant_d = 1'b0;
                ptr_d   = owner_inc;
            end else begin
                state_d = StIssue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            grant_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART and byte-queue requesters.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned START_TIMEOUT = 8;
`ifdef UART_ARB_HEADER_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_transmit;
    logic [7:0]           uart_tx_byte;
    logic                 uart_busy = 1'b0;
    logic                 grant_active;
    logic [1:0]           grant_id;
    logic                 timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .uart_transmit_o (uart_transmit),
        .uart_tx_byte_o  (uart_tx_byte),
        .uart_busy_i     (uart_busy),
        .grant_active_o  (grant_active),
        .grant_id_o      (grant_id),
        .timeout_err_o   (timeout_err)
    );

    logic [8:0]         mem [NUM_REQ][8];
    int                 rd [NUM_REQ];
    int                 wr [NUM_REQ];
    bit                 en [NUM_REQ];
    bit                 model_en;
    int                 busy_len;
    bit                 dly;
    int                 len_left;
    int                 cyc;
    bit                 tx_seen;
    logic [NUM_REQ-1:0] rdy_seen;
    logic [7:0]         raw_log [64];
    int                 raw_cyc [64];
    int                 raw_n;
    logic [7:0]         dat_log [64];
    int                 dat_n;
    int                 rdy_cnt [NUM_REQ];
    int                 rdy_cyc [NUM_REQ];
    int                 to_cyc [16];
    int                 to_n;
    int                 overlap_n;
    bit                 busy_prev, grant_prev;
    int                 busy_fall_cyc, grant_fall_cyc;
    int                 vec_n, miss_n;
    int                 n0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            miss_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({req_ready, uart_transmit, uart_tx_byte, grant_active, grant_id, timeout_err});
    endfunction

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][wr[i]] = {l, d};
        wr[i]++;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            en[i] = 1'b1;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic clear_mon();
        cyc            = 0;
        raw_n          = 0;
        dat_n          = 0;
        to_n           = 0;
        busy_fall_cyc  = -1;
        grant_fall_cyc = -2;
        for (int i = 0; i < NUM_REQ; i++) begin
            rdy_cnt[i] = 0;
            rdy_cyc[i] = -1;
        end
    endtask

    // One clock: UART model and requesters update after the edge, outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            uart_busy = 1'b0;
            dly       = 1'b0;
            len_left  = 0;
        end else begin
            if (uart_busy) begin
                if (len_left == 0) uart_busy = 1'b0;
                else len_left--;
            end else if (dly) begin
                dly = 1'b0;
                if (model_en) begin
                    uart_busy = 1'b1;
                    len_left  = busy_len - 1;
                end
            end
            if (tx_seen) dly = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy_seen[i]) rd[i]++;
            req_valid[i]      = en[i] && (rd[i] < wr[i]);
            req_data[i*8 +: 8] = (rd[i] < wr[i]) ? mem[i][rd[i]][7:0] : 8'h00;
            req_last[i]       = (rd[i] < wr[i]) ? mem[i][rd[i]][8] : 1'b0;
        end
        @(negedge clk);
        cyc++;
        tx_seen  = uart_transmit;
        rdy_seen = req_ready;
        if (uart_transmit && raw_n < 64) begin
            if (uart_busy) overlap_n++;
            raw_log[raw_n] = uart_tx_byte;
            raw_cyc[raw_n] = cyc;
            raw_n++;
            if (|req_ready) begin
                dat_log[dat_n] = uart_tx_byte;
                dat_n++;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                rdy_cnt[i]++;
                rdy_cyc[i] = cyc;
            end
        end
        if (timeout_err && to_n < 16) begin
            to_cyc[to_n] = cyc;
            to_n++;
        end
        if (busy_prev && !uart_busy) busy_fall_cyc = cyc;
        if (grant_prev && !grant_active) grant_fall_cyc = cyc;
        busy_prev  = uart_busy;
        grant_prev = grant_active;
    endtask

    task automatic reset_begin();
        rst = 1'b1;
        clear_reqs();
        step();
        step();
        chk("reset_outputs", outs(), 32'h0);
    endtask

    task automatic reset_end();
        rst = 1'b0;
        tx_seen  = 1'b0;
        rdy_seen = '0;
        clear_mon();
    endtask

    initial begin
        vec_n     = 0;
        miss_n    = 0;
        overlap_n = 0;
        model_en  = 1'b1;
        busy_len  = 40;
        dly       = 1'b0;
        len_left  = 0;
        tx_seen   = 1'b0;
        rdy_seen  = '0;
        busy_prev = 1'b0;
        grant_prev = 1'b0;
        clear_reqs();
        clear_mon();

        // Single byte 0x55 from req 0, long busy.
        reset_begin();
        reset_end();
        push(0, 8'h55, 1'b1);
        for (int k = 0; k < 120; k++) step();
        chk("t1_strobes", raw_n, 1 + HDR_N);
        chk("t1_latency", raw_cyc[0], 2);
        chk("t1_byte", raw_log[HDR_N], 8'h55);
        chk("t1_ready_cnt", rdy_cnt[0], 1);
        chk("t1_ready_on_strobe", rdy_cyc[0], raw_cyc[HDR_N]);
        chk("t1_grant_fall", grant_fall_cyc, busy_fall_cyc + 1);
        chk("t1_idle", grant_active, 1'b0);

        // req 1 and 3 at reset release; req 0 joins mid-packet and loses to 3.
        busy_len = 4;
        reset_begin();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(3, 8'h33, 1'b1);
        reset_end();
        for (int k = 0; k < 3; k++) step();
        push(0, 8'h0A, 1'b1);
        for (int k = 0; k < 80; k++) step();
        chk("t2_count", dat_n, 4);
        chk("t2_order", {dat_log[0], dat_log[1], dat_log[2], dat_log[3]}, 32'h1112330A);
        chk("t2_ready3", rdy_cnt[3], 1);

        // Owner 2 stalls between bytes while req 0 waits.
        reset_begin();
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        reset_end();
        for (int k = 0; k < 50 && rdy_cnt[2] == 0; k++) step();
        chk("t3_first_accept", rdy_cnt[2], 1);
        en[2] = 1'b0;
        push(0, 8'h01, 1'b1);
        n0 = raw_n;
        for (int k = 0; k < 20; k++) step();
        chk("t3_gap_no_strobe", raw_n, n0);
        chk("t3_lock_held", {grant_active, grant_id}, 3'b110);
        en[2] = 1'b1;
        for (int k = 0; k < 60; k++) step();
        chk("t3_count", dat_n, 3);
        chk("t3_order", {dat_log[0], dat_log[1], dat_log[2]}, 24'h212201);

        // UART never goes busy: every byte times out.
        model_en = 1'b0;
        reset_begin();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b1);
        reset_end();
        for (int k = 0; k < 60; k++) step();
        chk("t4_strobes", raw_n, 2 + HDR_N);
        chk("t4_bytes", {dat_log[0], dat_log[1]}, 16'h4142);
        chk("t4_timeouts", to_n, 2 + HDR_N);
        chk("t4_timeout_delay", to_cyc[HDR_N] - raw_cyc[HDR_N], START_TIMEOUT);
        chk("t4_next_issue", raw_cyc[HDR_N + 1] - to_cyc[HDR_N], 1);
        chk("t4_released", grant_active, 1'b0);
        model_en = 1'b1;

`ifdef UART_ARB_HEADER_EN
        // Header byte precedes the data of req 3.
        reset_begin();
        push(3, 8'h7E, 1'b1);
        reset_end();
        for (int k = 0; k < 40; k++) step();
        chk("t5_strobes", raw_n, 2);
        chk("t5_bytes", {raw_log[0], raw_log[1]}, 16'hA37E);
        chk("t5_ready_cnt", rdy_cnt[3], 1);
        chk("t5_ready_on_data", rdy_cyc[3], raw_cyc[1]);
`endif

        // Reset while the first byte of a 3-byte packet is on the wire.
        busy_len = 6;
        reset_begin();
        push(2, 8'h61, 1'b0);
        push(2, 8'h62, 1'b0);
        push(2, 8'h63, 1'b1);
        reset_end();
        for (int k = 0; k < 50 && rdy_cnt[2] == 0; k++) step();
        for (int k = 0; k < 4; k++) step();
        chk("t6_busy_before_rst", {uart_busy, grant_active}, 2'b11);
        rst = 1'b1;
        clear_reqs();
        step();
        chk("t6_reset_outputs", outs(), 32'h0);
        reset_end();
        push(1, 8'h15, 1'b1);
        for (int k = 0; k < 40; k++) step();
        chk("t6_latency", raw_cyc[0], 2);
        chk("t6_count", dat_n, 1);
        chk("t6_byte", dat_log[0], 8'h15);
        chk("t6_ready1", rdy_cnt[1], 1);
        chk("t6_released", grant_active, 1'b0);

        chk("no_strobe_while_busy", overlap_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmitter (8N2, transmit-strobe/is_transmitting handshake) among NUM_REQ byte-stream requesters.
- Each requester presents packets as bytes with valid/ready/last.
- Arbitration is round-robin at packet granularity: once a requester is granted, it owns the UART until its last byte is accepted.
- Sits between debug/status producers (e.g. display status, command responses) and the uart instance in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- START_TIMEOUT, 8, max clk cycles from uart_transmit to uart_busy rising before the byte is declared lost.

Ports:
- clk  in  1  master clock, shared with uart.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its packet.
- req_ready  out  NUM_REQ  one-cycle pulse: byte of owner accepted.
- uart_transmit  out  1  connects to uart transmit.
- uart_tx_byte  out  8  connects to uart tx_byte.
- uart_busy  in  1  connects to uart is_transmitting.
- grant_active  out  1  a packet is in progress.
- grant_id  out  max(1,$clog2(NUM_REQ))  current owner index.
- timeout_err  out  1  one-cycle pulse: uart did not start a byte.

Behaviour:
- Reset values: state IDLE, all outputs 0, owner 0, round-robin pointer 0, timeout counter 0.
- States:
  - IDLE
  - HDR (feature only)
  - ISSUE
  - WAIT_START
  - WAIT_END
- IDLE:
  - If any req_valid, pick the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - Register it as owner; grant_active<=1; go to ISSUE (HDR with feature).
  - Grant-to-strobe latency is 1 cycle.
- ISSUE:
  - uart_transmit = req_valid[owner] and uart_busy==0.
  - uart_tx_byte = owner's req_data.
  - req_ready[owner] = uart_transmit, in the same cycle (combinational from registered state).
  - On the strobe, latch req_last into last_q, clear the timeout counter, go to WAIT_START.
  - If owner's valid is low, remain in ISSUE holding the lock. Other requesters are never served mid-packet.
- WAIT_START:
  - Wait for uart_busy=1, then go to WAIT_END.
  - The counter increments each cycle. If it reaches START_TIMEOUT with busy still 0: pulse timeout_err, treat the byte as sent, proceed as if WAIT_END completed.
- WAIT_END:
  - On uart_busy=0: if last_q, go to IDLE, grant_active<=0, pointer<=owner+1 (wrap at NUM_REQ-1 -> 0).
  - Otherwise go to ISSUE.
- Only one uart_transmit per byte; never asserted while uart_busy=1. Back-to-back bytes have at least 1 idle cycle between the busy fall and the next strobe.
- Single requester, or all others idle: the owner is re-granted immediately after its packet (pointer wraps to it).
- Simultaneous requests are resolved purely by pointer; requesters not granted hold valid (standard valid/ready, data stable while valid).
- Reset mid-packet:
  - Return to IDLE in the next cycle; drop remaining packet state; pointer 0.
  - A uart byte already in flight is truncated by the uart's own reset (same rst).
- req_last on a 1-byte packet: ISSUE -> WAIT_START -> WAIT_END -> IDLE.

Optional Feature:
- UART_ARB_HEADER_EN defined:
  - After each grant, the HDR state sends one header byte {4'hA, grant_id[3:0]} using the ISSUE/WAIT_START/WAIT_END handshake.
  - No req_ready is issued for the header; the flow then enters ISSUE for data.
  - Timeout applies to the header byte too.
- Undefined: HDR state is absent and IDLE goes directly to ISSUE. NUM_REQ must be ≤16 when defined (elaboration check).

Decomposition:
- Package uart_arb_pkg:
  - state enum arb_state_t.
  - HDR_PREFIX = 4'hA.
  - function for id width.
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: req vector, pointer. Outputs: found, index.
  - Instantiated once.

Test Plan:
- Single byte 0x55 from req 0, uart model busy 2 cycles after strobe for 40 cycles:
  - exactly one uart_transmit with uart_tx_byte=0x55.
  - req_ready[0] pulses once.
  - grant_active falls after busy falls.
- req 1 and req 3 both valid at reset release, pointer 0:
  - req 1 packet (0x11,0x12 last) fully sent before req 3 byte 0x33.
  - Pointer then 2; next simultaneous request 0/3 serves 3 first.
- Owner req 2 drops valid between bytes for 20 cycles while req 0 is valid:
  - no strobe in the gap; req 0 is not served until req 2's last byte.
- uart_busy held 0 after strobe:
  - timeout_err pulses exactly START_TIMEOUT cycles after the strobe.
  - Next byte issued; no hang.
- UART_ARB_HEADER_EN, req 3 sends 0x7E last:
  - uart sees 0xA3 then 0x7E.
  - req_ready[3] pulses only on the 0x7E strobe.
- rst asserted during WAIT_END of a 3-byte packet:
  - Next cycle: state IDLE, all outputs 0.
  - New request from req 1 is granted normally.
